// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply and restoring
// divide on operand magnitudes, with single-cycle fast paths for divide corner cases.
module ex_mdu #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_i,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o,
    output logic            busy
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0]     CNT_INIT = CW'(STEPS - 1);
    localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO_2X  = {(2*XLEN){1'b0}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [2:0]          op_r;
    logic [4:0]          rd_r;
    logic [XLEN-1:0]     b_r, hi_r, lo_r, result_r;
    logic                neg_r, rem_neg_r;
    logic [CW-1:0]       cnt_r;

    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s, fast_res_s;
    logic                div_zero_s, ovf_s, fast_s, accept_s;
    logic [XLEN-1:0]     hi_nxt_s, lo_nxt_s;
    logic [XLEN:0]       rem_sh_s, diff_s, sum_s;
    logic [2*XLEN-1:0]   prod_s, prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s, calc_res_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign result    = result_r;
    assign rd_o      = rd_r;

    // Request decode: signedness, magnitudes and divide corner cases
    always_comb begin
        a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg_s    = a_signed_s & rs1[XLEN-1];
        b_neg_s    = b_signed_s & rs2[XLEN-1];
        a_mag_s    = a_neg_s ? (ZERO_X - rs1) : rs1;
        b_mag_s    = b_neg_s ? (ZERO_X - rs2) : rs2;
        div_zero_s = op[2] & (rs2 == ZERO_X);
        ovf_s      = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MIN_X) && (rs2 == ONES_X);
        fast_s     = div_zero_s | ovf_s;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_s) begin
            fast_res_s = op[1] ? rs1 : ONES_X;
        end else begin
            fast_res_s = op[1] ? ZERO_X : rs1;
        end
        accept_s = in_valid & in_ready & ~flush;
    end

    // UNROLL sub-steps of shift-add multiply or restoring divide
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        rem_sh_s = {(XLEN+1){1'b0}};
        diff_s   = {(XLEN+1){1'b0}};
        sum_s    = {(XLEN+1){1'b0}};
        for (int i = 0; i < UNROLL; i++) begin
            if (op_r[2]) begin
                rem_sh_s = {hi_nxt_s, lo_nxt_s[XLEN-1]};
                diff_s   = rem_sh_s - {1'b0, b_r};
                lo_nxt_s = {lo_nxt_s[XLEN-2:0], ~diff_s[XLEN]};
                hi_nxt_s = diff_s[XLEN] ? rem_sh_s[XLEN-1:0] : diff_s[XLEN-1:0];
            end else begin
                sum_s = {1'b0, hi_nxt_s} + (lo_nxt_s[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
                {hi_nxt_s, lo_nxt_s} = {sum_s, lo_nxt_s[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up and result selection for the final iteration
    always_comb begin
        prod_s     = {hi_nxt_s, lo_nxt_s};
        prod_fix_s = neg_r ? (ZERO_2X - prod_s) : prod_s;
        quo_fix_s  = neg_r ? (ZERO_X - lo_nxt_s) : lo_nxt_s;
        rem_fix_s  = rem_neg_r ? (ZERO_X - hi_nxt_s) : hi_nxt_s;
        case (op_r)
            OP_MUL:                       calc_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              calc_res_s = quo_fix_s;
            OP_REM, OP_REMU:              calc_res_s = rem_fix_s;
            default:                      calc_res_s = ZERO_X;
        endcase
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = in_valid ? (fast_s ? DONE : CALC) : IDLE;
                CALC:    state_nxt_s = (cnt_r == CNT_ZERO) ? DONE : CALC;
                DONE:    state_nxt_s = out_ready ? IDLE : DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration registers and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= 3'd0;
            rd_r      <= 5'd0;
            b_r       <= ZERO_X;
            hi_r      <= ZERO_X;
            lo_r      <= ZERO_X;
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
            result_r  <= ZERO_X;
        end else if (accept_s) begin
            op_r      <= op;
            rd_r      <= rd_i;
            b_r       <= b_mag_s;
            hi_r      <= ZERO_X;
            lo_r      <= a_mag_s;
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            cnt_r     <= fast_s ? CNT_ZERO : CNT_INIT;
            if (fast_s) begin
                result_r <= fast_res_s;
            end
        end else if ((state_r == CALC) && !flush) begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
            if (cnt_r == CNT_ZERO) begin
                result_r <= calc_res_s;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (XLEN=32, UNROLL=1) with hand-computed vectors.
module tb_ex_mdu;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  rd_i, rd_o;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .rd_i(rd_i), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .rd_o(rd_o), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for the result with a bound, check latency/result/tag, then hand off.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int   n;
        logic busy_ok;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; rs1 = a; rs2 = b; rd_i = rd;
        @(negedge clk);
        in_valid = 1'b0; rs1 = 32'h0; rs2 = 32'h0; rd_i = 5'd0;
        n = 1;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_rd"}, 64'(rd_o), 64'(rd));
        if (out_valid !== 1'b1) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end else begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        int   n;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = OP_MUL; rs1 = 32'h0; rs2 = 32'h0; rd_i = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd", 64'(rd_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
        run_op("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33);
        run_op("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 33);
        run_op("mulhsu_m1x2", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, 33);
        run_op("mulh_m3x5", OP_MULH, 32'hFFFFFFFD, 32'd5, 5'd5, 32'hFFFFFFFF, 33);
        run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 33);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd9, 32'd2, 33);
        run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, 5'd10, 32'hFFFFFFF2, 33);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 5'd11, 32'hFFFFFFFF, 1);
        run_op("remu_by0", OP_REMU, 32'd100, 32'd0, 5'd12, 32'd100, 1);
        run_op("rem_by0_neg", OP_REM, 32'hFFFFFFFB, 32'd0, 5'd13, 32'hFFFFFFFB, 1);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
        run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 1);

        // Back-pressure: hold out_ready low for 5 DONE cycles while pulsing in_valid
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd_i = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 64'(n), 64'd33);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); op = OP_MUL; rs1 = 32'd5; rs2 = 32'd5; rd_i = 5'd30;
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(result), 64'd14);
            check("bp_rd", 64'(rd_o), 64'd9);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_handoff_valid", 64'(out_valid), 64'd0);
        check("bp_handoff_idle", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("bp_no_queue", 64'(busy), 64'd0);

        // Flush in CALC cycle 10, then a fresh op must complete normally
        @(negedge clk);
        in_valid = 1'b1; op = OP_MUL; rs1 = 32'h00012345; rs2 = 32'h00000777; rd_i = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 33);

        // Reset mid-CALC discards the operation
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; rd_i = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_result", 64'(result), 64'd0);
        check("rst_mid_rd", 64'(rd_o), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_valid", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 The module SHALL have parameter UNROLL, default 1, meaning quotient/product bits retired per cycle; legal values divide XLEN evenly.
REQ-003 The module SHALL have port clk, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit, operation request.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the block can accept a request.
REQ-007 The module SHALL have port op, input, 3 bits, encoded 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 The module SHALL have ports rs1 and rs2, input, XLEN bits each, the operands.
REQ-009 The module SHALL have port rd_i, input, 5 bits, the destination register tag.
REQ-010 The module SHALL have port flush, input, 1 bit, which aborts the in-flight operation.
REQ-011 The module SHALL have port out_valid, output, 1 bit, meaning the result is available.
REQ-012 The module SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-013 The module SHALL have ports result (XLEN bits) and rd_o (5 bits), outputs carrying the result and the tag captured at accept.
REQ-014 The module SHALL have port busy, output, 1 bit, asserted whenever the state is not IDLE; it serves as the pipeline stall request.

Function
REQ-015 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); accept occurs on a rising edge when in_valid and in_ready are both high.
REQ-017 On accept, op, rd_i and operand magnitudes and signs SHALL be registered.
REQ-018 After accept, the state SHALL go to CALC with the iteration counter set to XLEN/UNROLL-1.
REQ-019 Multiply SHALL be iterative shift-add over unsigned magnitudes, producing a 2*XLEN-bit product that is negated if the operand signs differ.
REQ-020 Operand signedness SHALL be: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU and MUL unsigned-equivalent.
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 Divide SHALL be restoring, one quotient bit per sub-step and UNROLL sub-steps per cycle, on magnitudes.
REQ-023 The quotient SHALL be negated iff the operand signs differ (DIV only), and the remainder SHALL take the sign of the dividend (REM only).
REQ-024 CALC SHALL decrement the counter each cycle; at counter 0 the result register SHALL load and the state SHALL go to DONE.
REQ-025 Latency SHALL be: out_valid high exactly XLEN/UNROLL+1 cycles after the accept edge.
REQ-026 Fast paths SHALL skip CALC, going IDLE to DONE with out_valid high 1 cycle after accept:
- divide by zero: DIV/DIVU quotient all ones; REM/REMU result = rs1.
- signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones): DIV result = rs1; REM result = 0.
REQ-027 In DONE, out_valid SHALL be 1, and result/rd_o SHALL be held stable until out_ready is high; on out_valid & out_ready the state SHALL go to IDLE.
REQ-028 out_valid SHALL be 0 in IDLE and CALC.
REQ-029 flush SHALL force the state to IDLE on the next edge from any state, with no out_valid for the aborted op; flush takes priority over completion and handoff on the same edge.
REQ-030 in_valid asserted while in_ready is low SHALL be ignored, with no queuing.

Reset
REQ-031 While rst is high at a clock edge: state=IDLE, out_valid=0, result=0, rd_o=0, busy=0, counter=0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst is released.
REQ-033 rst asserted mid-CALC SHALL discard the operation, and no result is ever produced.

Verification (XLEN=32, UNROLL=1)
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid 33 cycles after accept; busy high throughout.
REQ-035 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-036 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, out_valid 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same -> 0.
REQ-038 out_ready held low 5 cycles in DONE -> result, rd_o and out_valid stable; in_valid pulses during this time are ignored; IDLE follows the cycle after out_ready rises.
REQ-039 flush at CALC cycle 10 -> in_ready high next cycle, out_valid never asserted; a fresh MUL 3x4 then returns 12 with the new rd_o.
